image_capture: RTL and testbench



---
 rtl/image_capture.sv | 98 +++++++++
 tb/tb_image_capture.sv | 138 +++++++++++++
 2 files changed

// File: rtl/image_capture.sv
// image_capture: captures one two-pixels-per-clock RGB frame in BMP bottom-up row order, with a registered read port
// Ports: HCLK rising-edge clock, HRESETn async active-low reset;
//        hsync qualifies the pixel pair DATA_WRITE_{R,G,B}0 (even) / DATA_WRITE_{R,G,B}1 (odd);
//        clear re-arms for the next frame; rd_en/rd_addr -> rd_data/rd_valid one cycle later;
//        frame_done one-cycle pulse, capture_done level, overflow sticky, pixel_count pixels this frame.
module image_capture #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              hsync,
  input  logic [7:0]        DATA_WRITE_R0,
  input  logic [7:0]        DATA_WRITE_G0,
  input  logic [7:0]        DATA_WRITE_B0,
  input  logic [7:0]        DATA_WRITE_R1,
  input  logic [7:0]        DATA_WRITE_G1,
  input  logic [7:0]        DATA_WRITE_B1,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_data,
  output logic              rd_valid,
  output logic              frame_done,
  output logic              capture_done,
  output logic              overflow,
  output logic [ADDR_W:0]   pixel_count
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int DEPTH = NPIX / 2;
  localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW    = WIDTH > 2 ? $clog2(WIDTH) : 1;
  localparam int RW    = $clog2(HEIGHT + 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] col_pair;
  logic [RW-1:0] row;
  logic [47:0] mem [DEPTH];
  logic accept, row_end, last;
  logic [IW-1:0] wr_idx, rd_idx;
  // each memory word holds {even, odd} pixel; word index = pixel address / 2
  assign accept  = hsync && !clear && state != DONE;
  assign row_end = col_pair == CW'(WIDTH / 2 - 1);
  assign last    = accept && row_end && row == RW'(HEIGHT - 1);
  assign wr_idx  = IW'((HEIGHT - 1 - int'(row)) * (WIDTH / 2) + int'(col_pair));
  assign rd_idx  = IW'(rd_addr >> 1);
  always_comb begin
    state_nxt = clear ? IDLE : last ? DONE : accept ? CAPTURE : state;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge HCLK) begin
    if (accept)
      mem[wr_idx] <= {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0, DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1};
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_pair     <= '0;
      row          <= '0;
      pixel_count  <= '0;
      frame_done   <= 1'b0;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_done <= last;
      if (clear) begin
        col_pair     <= '0;
        row          <= '0;
        pixel_count  <= '0;
        capture_done <= 1'b0;
        overflow     <= 1'b0;
      end else begin
        if (accept) begin
          col_pair    <= row_end ? '0 : col_pair + 1'b1;
          pixel_count <= pixel_count + (ADDR_W + 1)'(2);
          if (row_end) row <= last ? '0 : row + 1'b1;
        end
        if (last) capture_done <= 1'b1;
        if (hsync && state == DONE) overflow <= 1'b1;
      end
    end
  end
  // reads sample the memory before this edge's write lands, giving read-before-write
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= {1'b0, rd_addr} < (ADDR_W + 1)'(NPIX) ?
                   (rd_addr[0] ? mem[rd_idx][23:0] : mem[rd_idx][47:24]) : '0;
    end
  end
endmodule

// File: tb/tb_image_capture.sv
// tb_image_capture: randomized self-checking bench for image_capture against a frame-level reference model
module tb_image_capture;
  localparam int W = 4, H = 2, AW = 4, NP = W * H;
  logic HCLK = 0, HRESETn = 0, hsync = 0, clear = 0, rd_en = 0;
  logic [7:0] r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
  logic [AW-1:0] rd_addr = 0;
  logic [23:0] rd_data;
  logic rd_valid, frame_done, capture_done, overflow;
  logic [AW:0] pixel_count;
  image_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsync(hsync),
    .DATA_WRITE_R0(r0), .DATA_WRITE_G0(g0), .DATA_WRITE_B0(b0),
    .DATA_WRITE_R1(r1), .DATA_WRITE_G1(g1), .DATA_WRITE_B1(b1),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_done(frame_done), .capture_done(capture_done), .overflow(overflow), .pixel_count(pixel_count)
  );
  always #5 HCLK = ~HCLK;
  logic [23:0] mm [NP];
  bit mk [NP];
  int pairs;
  bit e_done, e_ovf, e_fd, e_rv, e_rdk;
  logic [23:0] e_rd;
  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outs();
    check("rd_valid", 32'(rd_valid), 32'(e_rv));
    if (e_rdk) check("rd_data", 32'(rd_data), 32'(e_rd));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("capture_done", 32'(capture_done), 32'(e_done));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("pixel_count", 32'(pixel_count), 32'(pairs * 2));
  endtask
  function automatic logic [23:0] px(input logic [7:0] r);
    return {r, 16'($urandom)};
  endfunction
  task automatic cycle(input bit hs, input bit clr, input bit ren, input logic [AW-1:0] ra,
                       input logic [23:0] p0, input logic [23:0] p1);
    int row, col, a;
    hsync = hs; clear = clr; rd_en = ren; rd_addr = ra;
    {r0, g0, b0} = p0; {r1, g1, b1} = p1;
    e_rv = ren;
    if (ren) begin
      if (int'(ra) < NP) begin e_rd = mm[ra]; e_rdk = mk[ra]; end
      else begin e_rd = '0; e_rdk = 1; end
    end
    e_fd = 0;
    if (clr) begin pairs = 0; e_done = 0; e_ovf = 0; end
    else if (hs && e_done) e_ovf = 1;
    else if (hs) begin
      row = pairs / (W / 2);
      col = pairs % (W / 2);
      a = (H - 1 - row) * W + 2 * col;
      mm[a] = p0; mm[a+1] = p1; mk[a] = 1; mk[a+1] = 1;
      pairs++;
      if (pairs == NP / 2) begin e_fd = 1; e_done = 1; end
    end
    @(posedge HCLK); #1;
    check_outs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, '0);
  endtask
  task automatic rd(input logic [AW-1:0] a);
    cycle(0, 0, 1, a, '0, '0);
  endtask
  task automatic do_reset();
    #2 HRESETn = 0; hsync = 0; clear = 0; rd_en = 1;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_capture_done", 32'(capture_done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_pixel_count", 32'(pixel_count), 0);
    @(posedge HCLK); #1;
    check("rst_rd_valid_hold", 32'(rd_valid), 0);
    HRESETn = 1; rd_en = 0;
    pairs = 0; e_done = 0; e_ovf = 0; e_fd = 0; e_rv = 0; e_rd = '0; e_rdk = 1;
  endtask
  task automatic send_frame(input logic [7:0] b0v, input logic [7:0] b1v, input int gp, input int gr);
    for (int k = 0; k < NP / 2; k++) begin
      cycle(1, 0, 0, '0, px(b0v + 8'(k)), px(b1v + 8'(k)));
      if (k < NP / 2 - 1) idle(k % (W / 2) == W / 2 - 1 ? gr : gp);
    end
  endtask
  initial begin
    for (int i = 0; i < NP; i++) begin mm[i] = '0; mk[i] = 0; end
    @(posedge HCLK); #1;
    do_reset();
    idle(2);
    send_frame(8'h10, 8'h20, 0, 0);
    idle(1);
    rd(4); check("rd4_R", 32'(rd_data[23:16]), 32'h10);
    rd(5); check("rd5_R", 32'(rd_data[23:16]), 32'h20);
    rd(0); check("rd0_R", 32'(rd_data[23:16]), 32'h12);
    rd(3); check("rd3_R", 32'(rd_data[23:16]), 32'h23);
    cycle(0, 1, 0, '0, '0, '0);
    send_frame(8'h10, 8'h20, 3, 5);
    rd(4); check("gap_rd4_R", 32'(rd_data[23:16]), 32'h10);
    rd(3); check("gap_rd3_R", 32'(rd_data[23:16]), 32'h23);
    cycle(1, 0, 0, '0, px(8'hFF), px(8'hFF));
    check("ovf_set", 32'(overflow), 1);
    cycle(1, 0, 0, '0, px(8'hFF), px(8'hFF));
    rd(0); check("ovf_rd0_R", 32'(rd_data[23:16]), 32'h12);
    check("ovf_count", 32'(pixel_count), 8);
    cycle(0, 1, 0, '0, '0, '0);
    check("clr_capture_done", 32'(capture_done), 0);
    check("clr_overflow", 32'(overflow), 0);
    cycle(1, 0, 1, 4, px(8'h40), px(8'h50));
    check("rbw_rd4_R", 32'(rd_data[23:16]), 32'h10);
    for (int k = 1; k < NP / 2; k++) cycle(1, 0, 0, '0, px(8'h40 + 8'(k)), px(8'h50 + 8'(k)));
    check("c_frame_done", 32'(frame_done), 1);
    rd(4); check("c_rd4_R", 32'(rd_data[23:16]), 32'h40);
    rd(9); check("oob_rd9", 32'(rd_data), 0);
    check("oob_valid", 32'(rd_valid), 1);
    cycle(0, 1, 0, '0, '0, '0);
    cycle(1, 0, 0, '0, px(8'h60), px(8'h70));
    cycle(1, 0, 0, '0, px(8'h61), px(8'h71));
    do_reset();
    send_frame(8'h80, 8'h90, 0, 0);
    check("rst_frame_done_after4", 32'(frame_done), 1);
    check("rst_count_after4", 32'(pixel_count), 8);
    rd(4); check("rst_rd4_R", 32'(rd_data[23:16]), 32'h80);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
                 AW'($urandom), px(8'($urandom)), px(8'($urandom)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
